digit_latch_bank: RTL and testbench

Parametrised snapshot register bank for the display path. On each rising edge of a slow sample strobe it captures CHANNELS digits of DIGIT_W bits from the counting logic and holds them stable for the display scanner until the next strobe. Compared with the previous fixed seven-digit latch it adds:

- parametrised channel count and digit width;
- a hold (freeze) input and a synchronous clear;
- update and change pulses;
- a capture counter;
- optional leading-zero blanking.

---
 rtl/digit_latch_bank.sv | 94 +++++++++
 tb/tb_digit_latch_bank.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_latch_bank.sv
// digit_latch_bank: snapshots CHANNELS digits on each rising edge of tick and holds them for the scanner.
// Leading-zero blanking is compiled in when DIGIT_LATCH_BLANK_EN is defined.
module digit_latch_bank #(
  parameter int         CHANNELS   = 7,
  parameter int         DIGIT_W    = 4,
  parameter int         CNT_W      = 8,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         hold,
  input  logic                         clear,
  input  logic [CHANNELS*DIGIT_W-1:0]  din,
  output logic [CHANNELS*DIGIT_W-1:0]  dout,
  output logic                         upd,
  output logic                         changed,
  output logic [CNT_W-1:0]             cap_cnt
);

  localparam int W = CHANNELS * DIGIT_W;

  logic           tick_q, tick_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           upd_q, upd_d;
  logic           changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           rise, cap;
  logic [W-1:0]   din_eff;

`ifdef DIGIT_LATCH_BLANK_EN
  localparam logic [DIGIT_W-1:0] BLANK_DIG = DIGIT_W'(BLANK_CODE);
  logic blank_run;

  // Walk down from the top channel; the first non-zero digit ends the blanked run.
  always_comb begin
    blank_run = 1'b1;
    din_eff   = din;
    for (int i = CHANNELS - 1; i >= 1; i--) begin
      if (blank_run && (din[i*DIGIT_W +: DIGIT_W] == '0)) begin
        din_eff[i*DIGIT_W +: DIGIT_W] = BLANK_DIG;
      end else begin
        blank_run = 1'b0;
      end
    end
  end
`else
  logic unused_blank_code;
  assign unused_blank_code = ^BLANK_CODE;
  assign din_eff           = din;
`endif

  assign rise = tick & ~tick_q;
  assign cap  = rise & ~hold & ~clear;

  always_comb begin
    tick_d    = tick;
    dout_d    = dout_q;
    upd_d     = 1'b0;
    changed_d = 1'b0;
    cnt_d     = cnt_q;
    if (clear) begin
      dout_d = '0;
      cnt_d  = '0;
    end else if (cap) begin
      dout_d    = din_eff;
      upd_d     = 1'b1;
      changed_d = (din_eff != dout_q);
      cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b0;
      dout_q    <= '0;
      upd_q     <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      tick_q    <= tick_d;
      dout_q    <= dout_d;
      upd_q     <= upd_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dout    = dout_q;
  assign upd     = upd_q;
  assign changed = changed_q;
  assign cap_cnt = cnt_q;

endmodule

// File: tb/tb_digit_latch_bank.sv
// Self-checking bench for digit_latch_bank; expected captures are queued when tick is driven
// and popped when the DUT's update cycle is sampled. Builds with or without DIGIT_LATCH_BLANK_EN.
module tb_digit_latch_bank;

  localparam int CH = 7;
  localparam int DW = 4;
  localparam int CW = 3;
  localparam int W  = CH * DW;

  logic          clk = 1'b0;
  logic          rst, tick, hold, clear;
  logic [W-1:0]  din, dout;
  logic          upd, changed;
  logic [CW-1:0] cap_cnt;

  digit_latch_bank #(
    .CHANNELS(CH), .DIGIT_W(DW), .CNT_W(CW), .BLANK_CODE(4'hF)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .hold(hold), .clear(clear),
    .din(din), .dout(dout), .upd(upd), .changed(changed), .cap_cnt(cap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  dout;
    logic          chg;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  logic [W-1:0]  m_dout;
  logic [CW-1:0] m_cnt;
  int            n_checks = 0;
  int            n_err    = 0;

  // Expected stored word: every channel above the highest non-zero digit becomes F (channel 0 kept).
  function automatic logic [W-1:0] blank_model(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
`ifdef DIGIT_LATCH_BLANK_EN
    begin
      int top;
      top = 0;
      for (int i = 0; i < CH; i++) if (d[i*DW +: DW] != 4'h0) top = i;
      for (int i = top + 1; i < CH; i++) r[i*DW +: DW] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic predict(input logic [W-1:0] d);
    exp_t e;
    logic [W-1:0] b;
    b      = blank_model(d);
    e.chg  = (b != m_dout);
    m_dout = b;
    m_cnt  = m_cnt + CW'(1);
    e.dout = b;
    e.cnt  = m_cnt;
    sb.push_back(e);
  endtask

  task automatic model_clear();
    m_dout = '0;
    m_cnt  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; hold = 1'b0; clear = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    model_clear();
    sb.delete();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {2'b00, CW'(0), W'(0)}) begin
      n_err++;
      $display("FAIL reset: got upd=%b chg=%b cnt=%0d dout=%h, want all zero", upd, changed, cap_cnt, dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    din = 28'h6543210; tick = 1'b1;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout}) begin
      n_err++;
      $display("FAIL basic_cap: got upd=%b chg=%b cnt=%0d dout=%h, want upd=1 chg=%b cnt=%0d dout=%h",
               upd, changed, cap_cnt, dout, e.chg, e.cnt, e.dout);
    end
    n_checks++;
    if ({dout, cap_cnt, changed} !== {28'h6543210, 3'd1, 1'b1}) begin
      n_err++;
      $display("FAIL basic_const: got dout=%h cnt=%0d chg=%b, want dout=6543210 cnt=1 chg=1", dout, cap_cnt, changed);
    end
    tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {2'b00, m_cnt, m_dout}) begin
      n_err++;
      $display("FAIL basic_pulse_end: got upd=%b chg=%b cnt=%0d dout=%h, want upd=0 chg=0 cnt=%0d dout=%h",
               upd, changed, cap_cnt, dout, m_cnt, m_dout);
    end
  endtask

  task automatic test_static_tick();
    exp_t e;
    tick = 1'b1;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout}) begin
      n_err++;
      $display("FAIL static_first: got upd=%b chg=%b cnt=%0d dout=%h, want upd=1 chg=%b cnt=%0d dout=%h",
               upd, changed, cap_cnt, dout, e.chg, e.cnt, e.dout);
    end
    for (int c = 0; c < 19; c++) begin
      din = W'($urandom());
      @(negedge clk);
      n_checks++;
      if ({upd, changed, cap_cnt, dout} !== {2'b00, m_cnt, m_dout}) begin
        n_err++;
        $display("FAIL static_hold_high[%0d]: got upd=%b cnt=%0d dout=%h, want upd=0 cnt=%0d dout=%h",
                 c, upd, cap_cnt, dout, m_cnt, m_dout);
      end
    end
    din = 28'h6543210; tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, 1'b0, e.cnt, e.dout} || e.chg !== 1'b0) begin
      n_err++;
      $display("FAIL repeat_value: got upd=%b chg=%b cnt=%0d dout=%h, want upd=1 chg=0 cnt=%0d dout=%h",
               upd, changed, cap_cnt, dout, e.cnt, e.dout);
    end
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    exp_t e;
    hold = 1'b1; din = 28'h1111111; tick = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {2'b00, m_cnt, m_dout}) begin
      n_err++;
      $display("FAIL hold_rise: got upd=%b cnt=%0d dout=%h, want upd=0 cnt=%0d dout=%h", upd, cap_cnt, dout, m_cnt, m_dout);
    end
    hold = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {2'b00, m_cnt, m_dout}) begin
      n_err++;
      $display("FAIL hold_release_high: got upd=%b cnt=%0d dout=%h, want upd=0 cnt=%0d dout=%h", upd, cap_cnt, dout, m_cnt, m_dout);
    end
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout} || dout !== 28'h1111111) begin
      n_err++;
      $display("FAIL hold_next_rise: got upd=%b chg=%b cnt=%0d dout=%h, want upd=1 chg=%b cnt=%0d dout=1111111",
               upd, changed, cap_cnt, dout, e.chg, e.cnt);
    end
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    exp_t e;
    clear = 1'b1; tick = 1'b1; din = 28'h2222222;
    @(negedge clk);
    model_clear();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {2'b00, CW'(0), W'(0)}) begin
      n_err++;
      $display("FAIL clear_vs_rise: got upd=%b chg=%b cnt=%0d dout=%h, want all zero", upd, changed, cap_cnt, dout);
    end
    clear = 1'b0; tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout}) begin
      n_err++;
      $display("FAIL clear_then_rise: got upd=%b chg=%b cnt=%0d dout=%h, want upd=1 chg=%b cnt=%0d dout=%h",
               upd, changed, cap_cnt, dout, e.chg, e.cnt, e.dout);
    end
    tick = 1'b0; hold = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    model_clear();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {2'b00, CW'(0), W'(0)}) begin
      n_err++;
      $display("FAIL clear_mid_hold: got upd=%b cnt=%0d dout=%h, want all zero", upd, cap_cnt, dout);
    end
    clear = 1'b0; hold = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [CW-1:0] want_c;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    for (int k = 0; k < 9; k++) begin
      din = W'($urandom());
      tick = 1'b1;
      predict(din);
      @(negedge clk);
      e = sb.pop_front();
      want_c = CW'(k + 1);
      n_checks++;
      if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout} || cap_cnt !== want_c) begin
        n_err++;
        $display("FAIL wrap[%0d]: got upd=%b chg=%b cnt=%0d dout=%h, want upd=1 chg=%b cnt=%0d dout=%h",
                 k, upd, changed, cap_cnt, dout, e.chg, want_c, e.dout);
      end
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_blank();
    exp_t e;
    logic [W-1:0] want1, want2;
`ifdef DIGIT_LATCH_BLANK_EN
    want1 = 28'hFFF4000;
    want2 = 28'hFFFFFF0;
`else
    want1 = 28'h0004000;
    want2 = 28'h0000000;
`endif
    din = 28'h0004000; tick = 1'b1;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout} || dout !== want1) begin
      n_err++;
      $display("FAIL blank_mid: got upd=%b cnt=%0d dout=%h, want upd=1 cnt=%0d dout=%h", upd, cap_cnt, dout, e.cnt, want1);
    end
    tick = 1'b0;
    @(negedge clk);
    din = '0; tick = 1'b1;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout} || dout !== want2) begin
      n_err++;
      $display("FAIL blank_zero: got upd=%b cnt=%0d dout=%h, want upd=1 cnt=%0d dout=%h", upd, cap_cnt, dout, e.cnt, want2);
    end
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_tick_high();
    exp_t e;
    rst = 1'b1; tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    din = 28'h9003000;
    predict(din);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({upd, changed, cap_cnt, dout} !== {1'b1, e.chg, e.cnt, e.dout} || cap_cnt !== CW'(1)) begin
      n_err++;
      $display("FAIL reset_tick_high: got upd=%b chg=%b cnt=%0d dout=%h, want upd=1 chg=%b cnt=1 dout=%h",
               upd, changed, cap_cnt, dout, e.chg, e.dout);
    end
    tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_static_tick();
    test_hold();
    test_clear();
    test_wrap();
    test_blank();
    test_reset_tick_high();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
